// File: rtl/breath_pwm_mc.sv
//----------------------------------------------------------------------------
// breath_pwm_mc : multi-channel PWM with off / fixed / breathe / blink modes
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module breath_pwm_mc #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 24,
  parameter int PERIOD   = 30000,
  parameter int STEP     = 10,
  parameter int STEP_DIV = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   en,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [WIDTH-1:0]      duty_fix,
  output logic [CHANNELS-1:0]   out,
  output logic                  period_start
);

  localparam logic [WIDTH-1:0] C_PERIOD    = WIDTH'(PERIOD);
  localparam logic [WIDTH-1:0] C_PERIOD_M1 = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] C_DIV_M1    = WIDTH'(STEP_DIV - 1);
  localparam logic [WIDTH:0]   C_PERIOD_X  = (WIDTH+1)'(PERIOD);
  localparam logic [WIDTH:0]   C_STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] C_STEP      = WIDTH'(STEP);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_FIXED   = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;

  logic [WIDTH-1:0] pwm_cnt_q;
  logic [WIDTH-1:0] div_cnt_q;
  logic             period_start_q;
  logic             wrap;
  logic             tick;

  assign wrap = (pwm_cnt_q == C_PERIOD_M1);
  assign tick = wrap && (div_cnt_q == C_DIV_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q      <= '0;
      div_cnt_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      pwm_cnt_q      <= wrap ? '0 : pwm_cnt_q + WIDTH'(1);
      if (wrap) begin
        div_cnt_q <= (div_cnt_q == C_DIV_M1) ? '0 : div_cnt_q + WIDTH'(1);
      end
      period_start_q <= (pwm_cnt_q == '0);
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]       ch_mode;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic             dir_q, dir_d;
    logic             blk_q, blk_d;
    logic             out_q;
    logic [WIDTH:0]   sum;

    assign ch_mode = mode[2*i +: 2];

    // Ramp uses the live mode so a change landing on the tick cycle wins.
    always_comb begin
      duty_d = duty_q;
      dir_d  = dir_q;
      blk_d  = blk_q;
      sum    = {1'b0, duty_q} + C_STEP_X;
      if (tick && en[i]) begin
        if (ch_mode == MODE_BREATHE) begin
          if (!dir_q) begin
            if (sum >= C_PERIOD_X) begin
              duty_d = C_PERIOD;
              dir_d  = 1'b1;
            end else begin
              duty_d = sum[WIDTH-1:0];
            end
          end else begin
            if ({1'b0, duty_q} <= C_STEP_X) begin
              duty_d = '0;
              dir_d  = 1'b0;
            end else begin
              duty_d = duty_q - C_STEP;
            end
          end
        end else if (ch_mode != MODE_OFF && ch_mode != MODE_FIXED) begin
          blk_d = ~blk_q;
        end
      end

      case (ch_mode)
        MODE_OFF:     act_d = '0;
        MODE_FIXED:   act_d = (duty_fix >= C_PERIOD) ? C_PERIOD : duty_fix;
        MODE_BREATHE: act_d = duty_d;
        default:      act_d = blk_d ? C_PERIOD : '0;
      endcase
      if (!en[i]) begin
        act_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        duty_q <= '0;
        dir_q  <= 1'b0;
        blk_q  <= 1'b0;
        act_q  <= '0;
        out_q  <= 1'b0;
      end else begin
        duty_q <= duty_d;
        dir_q  <= dir_d;
        blk_q  <= blk_d;
        if (wrap) begin
          act_q <= act_d;
        end
        out_q <= (pwm_cnt_q < act_q);
      end
    end

    assign out[i] = out_q;
  end : g_ch

endmodule

`default_nettype wire
